// File: rtl/word_entry_pkg.sv
// Shared types and ASCII constants for the hangman word-entry front end.
package word_entry_pkg;

    typedef enum logic [2:0] {
        ENTRY     = 3'd0,
        ARMED     = 3'd1,
        PLAY      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LZ = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;

endpackage

// File: rtl/word_entry_letter_normalize.sv
// Folds ASCII letters to uppercase and gives their alphabet index (A=0).
module letter_normalize
    import word_entry_pkg::*;
(
    input  logic [7:0] key_code,
    output logic       is_letter,
    output logic [7:0] upper,
    output logic [4:0] idx
);

    logic [7:0] ofs;

    always_comb begin
        is_letter = 1'b0;
        upper     = 8'h00;
        if (key_code >= ASCII_A && key_code <= ASCII_Z) begin
            is_letter = 1'b1;
            upper     = key_code;
        end else if (key_code >= ASCII_LA && key_code <= ASCII_LZ) begin
            is_letter = 1'b1;
            upper     = key_code - CASE_OFS;
        end
        ofs = upper - ASCII_A;
        idx = is_letter ? ofs[4:0] : 5'd0;
    end

endmodule

// File: rtl/word_entry.sv
// Secret-word entry, arming and guess-strobe generation in front of the hangman core.
module word_entry
    import word_entry_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int CHAR_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_valid,
    input  logic [7:0]                 key_code,
    input  logic                       key_enter,
    input  logic                       key_back,
    input  logic                       game_rdy,
    input  logic                       red_busy,
    input  logic                       gameEnd,
    output logic [WORD_LEN*CHAR_W-1:0] setWord,
    output logic                       toggle_state,
    output logic [7:0]                 guess,
    output logic [2:0]                 entry_count,
    output logic [25:0]                used_mask,
    output logic                       reject,
    output logic                       entry_mode
);

    localparam int         W    = WORD_LEN * CHAR_W;
    localparam logic [2:0] FULL = 3'(WORD_LEN);

    state_t         state_q;
    logic [W-1:0]   word_q;
    logic [2:0]     cnt_q;
    logic [25:0]    used_q;
    logic [7:0]     guess_q;
    logic           toggle_q;
    logic           reject_q;

    logic           is_letter;
    logic [7:0]     upper;
    logic [4:0]     idx;
    logic           any_key;

    letter_normalize u_norm (
        .key_code  (key_code),
        .is_letter (is_letter),
        .upper     (upper),
        .idx       (idx)
    );

    assign any_key = key_valid | key_enter | key_back;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ENTRY;
            word_q   <= '0;
            cnt_q    <= '0;
            used_q   <= '0;
            guess_q  <= '0;
            toggle_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            // Strobe outputs default low so each pulse lasts exactly one cycle.
            guess_q  <= '0;
            toggle_q <= 1'b0;
            reject_q <= 1'b0;
            if (gameEnd) begin
                state_q <= ENTRY;
                word_q  <= '0;
                cnt_q   <= '0;
                used_q  <= '0;
            end else begin
                case (state_q)
                    ENTRY: begin
                        if (key_enter) begin
                            if (cnt_q == FULL) begin
                                toggle_q <= 1'b1;
                                state_q  <= ARMED;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end else if (key_back) begin
                            if (cnt_q != 3'd0) begin
                                word_q <= {{CHAR_W{1'b0}}, word_q[W-1:CHAR_W]};
                                cnt_q  <= cnt_q - 3'd1;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end else if (key_valid) begin
                            if (is_letter && cnt_q != FULL) begin
                                word_q <= {word_q[W-CHAR_W-1:0], CHAR_W'(upper)};
                                cnt_q  <= cnt_q + 3'd1;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (game_rdy) state_q <= PLAY;
                        if (any_key) reject_q <= 1'b1;
                    end
                    PLAY: begin
                        // Enter/back are ignored here but still shadow a coincident letter.
                        if (key_valid && !key_enter && !key_back) begin
                            if (is_letter && !used_q[idx] && game_rdy && !red_busy) begin
                                guess_q     <= upper;
                                used_q[idx] <= 1'b1;
                                state_q     <= WAIT_ACK;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    WAIT_ACK: begin
                        if (red_busy) state_q <= WAIT_DONE;
                        if (any_key) reject_q <= 1'b1;
                    end
                    WAIT_DONE: begin
                        if (!red_busy && game_rdy) state_q <= PLAY;
                        if (any_key) reject_q <= 1'b1;
                    end
                    default: state_q <= ENTRY;
                endcase
            end
        end
    end

    assign setWord      = word_q;
    assign toggle_state = toggle_q;
    assign guess        = guess_q;
    assign entry_count  = cnt_q;
    assign used_mask    = used_q;
    assign reject       = reject_q;
    assign entry_mode   = (state_q == ENTRY);

endmodule

// File: tb/tb_word_entry.sv
// Vector-table bench for word_entry with a one-deep expected-result scoreboard.
module tb_word_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_enter;
    logic        key_back;
    logic        game_rdy;
    logic        red_busy;
    logic        gameEnd;
    logic [39:0] setWord;
    logic        toggle_state;
    logic [7:0]  guess;
    logic [2:0]  entry_count;
    logic [25:0] used_mask;
    logic        reject;
    logic        entry_mode;

    word_entry dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_enter    (key_enter),
        .key_back     (key_back),
        .game_rdy     (game_rdy),
        .red_busy     (red_busy),
        .gameEnd      (gameEnd),
        .setWord      (setWord),
        .toggle_state (toggle_state),
        .guess        (guess),
        .entry_count  (entry_count),
        .used_mask    (used_mask),
        .reject       (reject),
        .entry_mode   (entry_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        kv;
        logic [7:0]  kc;
        logic        ke;
        logic        kb;
        logic        rdy;
        logic        busy;
        logic        ge;
        logic [39:0] sw;
        logic [7:0]  g;
        logic [2:0]  cnt;
        logic [25:0] um;
        logic        rej;
        logic        tog;
        logic        em;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   step_no = 0;

    localparam logic [39:0] HELLO = 40'h48454C4C4F;
    localparam logic [25:0] UQ    = 26'h0010000;
    localparam logic [25:0] UQB   = 26'h0010002;

    function automatic vec_t mk(input logic r, input logic kv, input logic [7:0] kc,
                                input logic ke, input logic kb, input logic rdy,
                                input logic busy, input logic ge, input logic [39:0] sw,
                                input logic [7:0] g, input logic [2:0] cnt,
                                input logic [25:0] um, input logic rej, input logic tog,
                                input logic em);
        vec_t v;
        v.r = r; v.kv = kv; v.kc = kc; v.ke = ke; v.kb = kb; v.rdy = rdy;
        v.busy = busy; v.ge = ge; v.sw = sw; v.g = g; v.cnt = cnt; v.um = um;
        v.rej = rej; v.tog = tog; v.em = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, expv);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        rst = v.r; key_valid = v.kv; key_code = v.kc; key_enter = v.ke;
        key_back = v.kb; game_rdy = v.rdy; red_busy = v.busy; gameEnd = v.ge;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        rst = 1'b0; key_valid = 1'b0; key_code = 8'h00; key_enter = 1'b0;
        key_back = 1'b0; gameEnd = 1'b0;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", step_no);
        end else begin
            e = exp_q.pop_front();
            check("setWord",      40'(setWord),      40'(e.sw));
            check("guess",        40'(guess),        40'(e.g));
            check("entry_count",  40'(entry_count),  40'(e.cnt));
            check("used_mask",    40'(used_mask),    40'(e.um));
            check("reject",       40'(reject),       40'(e.rej));
            check("toggle_state", 40'(toggle_state), 40'(e.tog));
            check("entry_mode",   40'(entry_mode),   40'(e.em));
        end
        step_no++;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00; key_enter = 1'b0;
        key_back = 1'b0; game_rdy = 1'b0; red_busy = 1'b0; gameEnd = 1'b0;
        @(posedge clk);
        #1;

        // reset with a coincident key: everything cleared, in ENTRY
        step(mk(1,1,8'h41,0,0,0,0,0, 40'h0,8'h00,3'd0,26'h0,0,0,1));

        // r kv kc ke kb rdy busy ge | setWord guess cnt used rej tog em
        tbl.push_back(mk(0,1,8'h41,0,0,0,0,0, 40'h0000000041,8'h00,3'd1,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h42,0,0,0,0,0, 40'h0000004142,8'h00,3'd2,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h63,0,0,0,0,0, 40'h0000414243,8'h00,3'd3,26'h0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0,0, 40'h0000004142,8'h00,3'd2,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h44,0,0,0,0,0, 40'h0000414244,8'h00,3'd3,26'h0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,1,0,0,0,0, 40'h0000414244,8'h00,3'd3,26'h0,1,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0,0, 40'h0000004142,8'h00,3'd2,26'h0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0,0, 40'h0000000041,8'h00,3'd1,26'h0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0,0, 40'h0000000000,8'h00,3'd0,26'h0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0,0, 40'h0000000000,8'h00,3'd0,26'h0,1,0,1));
        tbl.push_back(mk(0,1,8'h35,0,0,0,0,0, 40'h0000000000,8'h00,3'd0,26'h0,1,0,1));
        tbl.push_back(mk(0,1,8'h68,0,0,0,0,0, 40'h0000000048,8'h00,3'd1,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h65,0,0,0,0,0, 40'h0000004845,8'h00,3'd2,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h6C,0,0,0,0,0, 40'h000048454C,8'h00,3'd3,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h6C,0,0,0,0,0, 40'h0048454C4C,8'h00,3'd4,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h6F,0,0,0,0,0, HELLO,        8'h00,3'd5,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h5A,0,0,0,0,0, HELLO,        8'h00,3'd5,26'h0,1,0,1));
        tbl.push_back(mk(0,1,8'h61,1,0,0,0,0, HELLO,        8'h00,3'd5,26'h0,0,1,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0, HELLO,        8'h00,3'd5,26'h0,0,0,0));
        tbl.push_back(mk(0,1,8'h78,0,0,0,0,0, HELLO,        8'h00,3'd5,26'h0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0, HELLO,        8'h00,3'd5,26'h0,0,0,0));
        tbl.push_back(mk(0,1,8'h71,0,0,1,0,0, HELLO,        8'h51,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0, HELLO,        8'h00,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1,0, HELLO,        8'h00,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1,0, HELLO,        8'h00,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,1,8'h52,0,0,0,1,0, HELLO,        8'h00,3'd5,UQ,  1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,1,0, HELLO,        8'h00,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,1,0, HELLO,        8'h00,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0, HELLO,        8'h00,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,1,8'h51,0,0,1,0,0, HELLO,        8'h00,3'd5,UQ,  1,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0,1,0,0, HELLO,        8'h00,3'd5,UQ,  0,0,0));
        tbl.push_back(mk(0,1,8'h35,0,0,1,0,0, HELLO,        8'h00,3'd5,UQ,  1,0,0));
        tbl.push_back(mk(0,1,8'h62,0,0,1,0,0, HELLO,        8'h42,3'd5,UQB, 0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,1,0, HELLO,        8'h00,3'd5,UQB, 0,0,0));
        tbl.push_back(mk(0,1,8'h63,0,0,1,1,1, 40'h0,        8'h00,3'd0,26'h0,0,0,1));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0, 40'h0,        8'h00,3'd0,26'h0,0,0,1));
        tbl.push_back(mk(0,1,8'h6B,0,0,1,0,0, 40'h000000004B,8'h00,3'd1,26'h0,0,0,1));

        foreach (tbl[i]) step(tbl[i]);

        // backspace beats a coincident letter; then reset mid-entry clears the word
        step(mk(0,1,8'h4D,0,1,0,0,0, 40'h0,8'h00,3'd0,26'h0,0,0,1));
        step(mk(0,1,8'h4E,0,0,0,0,0, 40'h000000004E,8'h00,3'd1,26'h0,0,0,1));
        step(mk(1,1,8'h4F,0,0,0,0,0, 40'h0,8'h00,3'd0,26'h0,0,0,1));

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_entry.md
Name: word_entry

Overview:
- Upstream input stage for the hangman game core.
- Collects the host's 5-letter secret word from the keypad decoder into a shift register and presents it on setWord.
- Issues the one-cycle toggle_state that arms the core, then converts player key presses into single-cycle guess strobes.
- Handshakes on the core's game_rdy/red_busy, rejects duplicate and non-letter keys, and clears on gameEnd.

Parameters:
WORD_LEN, 5, letters in secret word (setWord width = WORD_LEN*CHAR_W)
CHAR_W, 8, bits per character (ASCII)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  8  ASCII code of pressed key
key_enter  in  1  one-cycle strobe, confirm key
key_back  in  1  one-cycle strobe, backspace key
game_rdy  in  1  core ready for a guess
red_busy  in  1  core comparing a guess
gameEnd  in  1  level, abort/restart game
setWord  out  40  secret word, first letter in [39:32]
toggle_state  out  1  one-cycle arm pulse to core
guess  out  8  uppercase letter for one cycle, else 8'h00
entry_count  out  3  letters entered so far (0..5)
used_mask  out  26  bit i set = letter 'A'+i already guessed
reject  out  1  one-cycle pulse, key refused
entry_mode  out  1  high while in ENTRY

Behaviour:
- Reset (rst high at a clk edge): state=ENTRY; setWord=0, entry_count=0, used_mask=0, guess=0, toggle_state=0, reject=0. entry_mode=1 (decoded from state). All outputs registered.
- Letter normalisation: 0x41–0x5A pass through; 0x61–0x7A have 0x20 subtracted. Any other code is non-letter.
- Key priority when strobes coincide: key_enter > key_back > key_valid. Lower-priority strobes are dropped silently.
- gameEnd overrides everything. In any state it forces ENTRY next cycle, clears setWord/entry_count/used_mask and forces guess=0; no reject pulse.
- ENTRY:
  - Letter with count<5: setWord <= {setWord[31:0], letter}; count+1.
  - Letter with count==5: reject.
  - Non-letter: reject.
  - key_back with count>0: setWord <= {8'h00, setWord[39:8]}; count-1.
  - key_back with count==0: reject.
  - key_enter with count==5: toggle_state=1 for exactly one cycle; go ARMED.
  - key_enter with count<5: reject.
- ARMED:
  - Wait for game_rdy==1, then go PLAY.
  - All keys are rejected.
  - setWord is frozen from here until gameEnd or rst.
- PLAY:
  - Letter L with used_mask[L-'A']==0, game_rdy==1 and red_busy==0: guess=L for exactly one cycle; set the used bit in the same edge; go WAIT_ACK.
  - Already-used letter: reject, no guess.
  - Non-letter: reject.
  - key_back and key_enter are ignored.
- WAIT_ACK: go WAIT_DONE on the first cycle red_busy==1. All keys are rejected.
- WAIT_DONE: return to PLAY when red_busy==0 and game_rdy==1. All keys are rejected.
- Latency: key strobe at edge N gives the guess/setWord/toggle_state/reject update visible after edge N+1 (one register stage).
- guess is never nonzero for two consecutive cycles. Zero is the core's "no guess" value.
- entry_count saturates at 5 and never wraps; setWord is unchanged on rejected keys.
- After the core signals win/loss it keeps game_rdy high. Further unused letters are still issued; the core ignores them.

Decomposition:
- Package word_entry_pkg holds:
  - state_t enum: ENTRY, ARMED, PLAY, WAIT_ACK, WAIT_DONE.
  - Constants ASCII_A=8'h41, ASCII_Z=8'h5A, ASCII_LA=8'h61, ASCII_LZ=8'h7A, CASE_OFS=8'h20.
- One combinational sub-module, letter_normalize: key_code in; is_letter, upper[7:0] and idx[4:0] out.

Test Plan:
- rst, then keys 'h','e','l','l','o', then enter -> setWord=40'h48454C4C4F, entry_count=5, one toggle_state pulse.
- 'A','B','C', back, 'D' -> setWord=40'h0000414244, count=3. Enter -> reject pulse, no toggle_state. Back at count 0 -> reject.
- 6th letter 'Z' at count 5 -> reject, setWord unchanged. '5' (0x35) in ENTRY -> reject.
- Armed, game_rdy=1, press 'q' -> guess=8'h51 for one cycle, used_mask[16]=1. Hold red_busy 5 cycles; 'R' during busy -> reject. Release -> PLAY.
- Second 'Q' in PLAY -> reject, guess stays 0, used_mask unchanged.
- gameEnd asserted in WAIT_DONE together with key_valid -> ENTRY next cycle, setWord=0, used_mask=0, no guess, no reject.
